// File: rtl/boot_slot_selector.sv
// Multiboot menu controller: select-then-confirm over SPI command bytes, then
// a single boot trigger with a stable flash address, locked until reset.
module boot_slot_selector #(
    parameter int unsigned NUM_SLOTS      = 2,
    parameter logic [31:0] SLOT_BASE      = 32'h0010_0000,
    parameter logic [31:0] SLOT_STRIDE    = 32'h0010_0000,
    parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
    parameter int unsigned BLINK_CYCLES   = 3_125_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        trigger,
    output logic [31:0] boot_address,
    output logic [3:0]  slot,
    output logic        armed,
    output logic        err,
    output logic        led_verde,
    output logic        led_verm
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [3:0]    MAX_K      = 4'(NUM_SLOTS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [7:0]    CMD_CONFIRM = 8'h5A;
    localparam logic [7:0]    CMD_ABORT   = 8'hC3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_FIRE,
        S_LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    slot_q, slot_d;
    logic          err_q, err_d;
    logic          verde_q, verde_d;
    logic          trigger_q, trigger_d;
    logic          armed_q, armed_d;
    logic          verm_q, verm_d;

    // Command decode
    logic [3:0]  sel_k;
    logic        is_sel, is_confirm, is_abort;
    logic [31:0] sel_addr;

    assign sel_k      = rx_data[3:0];
    assign is_sel     = (rx_data[7:4] == 4'hA) && (sel_k != 4'd0) && (sel_k <= MAX_K);
    assign is_confirm = (rx_data == CMD_CONFIRM);
    assign is_abort   = (rx_data == CMD_ABORT);
    assign sel_addr   = SLOT_BASE + SLOT_STRIDE * 32'(sel_k - 4'd1);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        blink_d = blink_q;
        addr_d  = addr_q;
        slot_d  = slot_q;
        err_d   = err_q;
        verde_d = verde_q;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                blink_d = '0;
                verde_d = 1'b1;
                if (rx_valid) begin
                    if (is_sel) begin
                        state_d = S_ARMED;
                        slot_d  = sel_k;
                        addr_d  = sel_addr;
                        err_d   = 1'b0;
                    end else if (!is_abort) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                timer_d = timer_q + TW'(1);
                if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                    verde_d = ~verde_q;
                end else begin
                    blink_d = blink_q + BW'(1);
                end
                // A byte on the expiry cycle takes priority over the timeout
                if (rx_valid) begin
                    if (is_sel) begin
                        slot_d  = sel_k;
                        addr_d  = sel_addr;
                        timer_d = '0;
                        blink_d = '0;
                        verde_d = 1'b1;
                        err_d   = 1'b0;
                    end else if (is_confirm) begin
                        state_d = S_FIRE;
                    end else if (is_abort) begin
                        state_d = S_IDLE;
                        slot_d  = 4'd0;
                    end else begin
                        state_d = S_IDLE;
                        slot_d  = 4'd0;
                        err_d   = 1'b1;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_IDLE;
                    slot_d  = 4'd0;
                    err_d   = 1'b1;
                end
            end
            S_FIRE:   state_d = S_LOCKED;
            S_LOCKED: state_d = S_LOCKED;
            default:  state_d = S_IDLE;
        endcase

        if (state_d != S_ARMED) begin
            verde_d = (state_d == S_IDLE);
        end
    end

    assign trigger_d = (state_d == S_FIRE);
    assign armed_d   = (state_d == S_ARMED);
    assign verm_d    = err_d | (state_d == S_LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            blink_q   <= '0;
            addr_q    <= SLOT_BASE;
            slot_q    <= 4'd0;
            err_q     <= 1'b0;
            verde_q   <= 1'b1;
            trigger_q <= 1'b0;
            armed_q   <= 1'b0;
            verm_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            blink_q   <= blink_d;
            addr_q    <= addr_d;
            slot_q    <= slot_d;
            err_q     <= err_d;
            verde_q   <= verde_d;
            trigger_q <= trigger_d;
            armed_q   <= armed_d;
            verm_q    <= verm_d;
        end
    end

    assign trigger      = trigger_q;
    assign boot_address = addr_q;
    assign slot         = slot_q;
    assign armed        = armed_q;
    assign err          = err_q;
    assign led_verde    = verde_q;
    assign led_verm     = verm_q;

endmodule

// File: tb/tb_boot_slot_selector.sv
// Bench for boot_slot_selector: directed command sequences, trigger scoreboard
// and direct checks of the status outputs.
module tb_boot_slot_selector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;

    logic        trigger, armed, err, led_verde, led_verm;
    logic [31:0] boot_address;
    logic [3:0]  slot;

    logic        w_trigger, w_armed, w_err, w_led_verde, w_led_verm;
    logic [31:0] w_boot_address;
    logic [3:0]  w_slot;

    always #5 clk = ~clk;

    boot_slot_selector #(
        .NUM_SLOTS(3), .TIMEOUT_CYCLES(20), .BLINK_CYCLES(4)
    ) u_dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .trigger(trigger), .boot_address(boot_address), .slot(slot),
        .armed(armed), .err(err), .led_verde(led_verde), .led_verm(led_verm)
    );

    // Second instance with a base near the top of the address space
    boot_slot_selector #(
        .NUM_SLOTS(3), .SLOT_BASE(32'hFFF0_0000), .TIMEOUT_CYCLES(20), .BLINK_CYCLES(4)
    ) u_wrap (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .trigger(w_trigger), .boot_address(w_boot_address), .slot(w_slot),
        .armed(w_armed), .err(w_err), .led_verde(w_led_verde), .led_verm(w_led_verm)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  slot;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic trig_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        rx_valid = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_trigger"}, 32'(trigger), 32'd0);
        chk({tag, "_addr"}, boot_address, 32'h0010_0000);
        chk({tag, "_slot"}, 32'(slot), 32'd0);
        chk({tag, "_armed"}, 32'(armed), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_verde"}, 32'(led_verde), 32'd1);
        chk({tag, "_verm"}, 32'(led_verm), 32'd0);
    endtask

    // Trigger monitor: every pulse must match the oldest expected boot request
    always @(negedge clk) begin
        if (trigger) begin
            total++;
            if (trig_prev) begin
                bad++;
                $display("FAIL trigger_width: trigger high on consecutive cycles, expected one cycle");
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_trigger: got trigger addr=%h slot=%0d, expected none",
                         boot_address, slot);
            end else begin
                if (boot_address !== exp_q[0].addr || slot !== exp_q[0].slot) begin
                    bad++;
                    $display("FAIL trigger_payload: got addr=%h slot=%0d expected addr=%h slot=%0d",
                             boot_address, slot, exp_q[0].addr, exp_q[0].slot);
                end
                void'(exp_q.pop_front());
            end
        end
        trig_prev <= trigger;
    end

    initial begin
        // Reset state
        do_reset();
        chk_reset_vals("rst");
        chk("wrap_rst_addr", w_boot_address, 32'hFFF0_0000);
        chk("wrap_rst_misc", {w_trigger, w_slot, w_armed, w_err, w_led_verde, w_led_verm},
            {1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0});

        // 1: select slot 2, confirm, then locked
        send(8'hA2);
        chk("t1_addr", boot_address, 32'h0020_0000);
        chk("t1_slot", 32'(slot), 32'd2);
        chk("t1_armed", 32'(armed), 32'd1);
        tick(2);
        exp_q.push_back('{addr: 32'h0020_0000, slot: 4'd2});
        send(8'h5A);
        chk("t1_trigger_hi", 32'(trigger), 32'd1);
        chk("t1_fire_verde", 32'(led_verde), 32'd0);
        tick(1);
        chk("t1_trigger_lo", 32'(trigger), 32'd0);
        chk("t1_locked_verm", 32'(led_verm), 32'd1);
        chk("t1_locked_armed", 32'(armed), 32'd0);
        send(8'hA1);
        tick(1);
        send(8'h5A);
        tick(3);
        chk("t1_locked_addr", boot_address, 32'h0020_0000);
        chk("t1_locked_slot", 32'(slot), 32'd2);
        chk("t1_locked_armed2", 32'(armed), 32'd0);

        // 2: timeout after 20 armed cycles
        do_reset();
        send(8'hA3);
        chk("t2_armed0", 32'(armed), 32'd1);
        tick(19);
        chk("t2_armed19", 32'(armed), 32'd1);
        tick(1);
        chk("t2_timeout_armed", 32'(armed), 32'd0);
        chk("t2_timeout_err", 32'(err), 32'd1);
        chk("t2_timeout_verm", 32'(led_verm), 32'd1);
        chk("t2_timeout_slot", 32'(slot), 32'd0);
        send(8'h5A);
        tick(2);
        chk("t2_confirm_idle_err", 32'(err), 32'd1);

        // 3: byte on the expiry cycle wins over the timeout
        do_reset();
        send(8'hA1);
        tick(18);
        exp_q.push_back('{addr: 32'h0010_0000, slot: 4'd1});
        send(8'h5A);
        chk("t3_expiry_trigger", 32'(trigger), 32'd1);
        chk("t3_expiry_err", 32'(err), 32'd0);
        do_reset();
        send(8'hA1);
        tick(18);
        send(8'hA3);
        chk("t3_resel_addr", boot_address, 32'h0030_0000);
        chk("t3_resel_slot", 32'(slot), 32'd3);
        chk("t3_resel_armed", 32'(armed), 32'd1);
        tick(19);
        chk("t3_restart_armed", 32'(armed), 32'd1);
        tick(1);
        chk("t3_restart_timeout", 32'(armed), 32'd0);

        // 4: bad bytes in IDLE, then a valid select clears err
        do_reset();
        send(8'hA4);
        chk("t4_a4_err", 32'(err), 32'd1);
        chk("t4_a4_armed", 32'(armed), 32'd0);
        send(8'hA0);
        chk("t4_a0_err", 32'(err), 32'd1);
        chk("t4_a0_armed", 32'(armed), 32'd0);
        send(8'h5A);
        chk("t4_5a_err", 32'(err), 32'd1);
        chk("t4_5a_armed", 32'(armed), 32'd0);
        send(8'hA1);
        chk("t4_sel_err", 32'(err), 32'd0);
        chk("t4_sel_armed", 32'(armed), 32'd1);
        chk("t4_sel_verm", 32'(led_verm), 32'd0);
        send(8'hC3);
        send(8'hC3);
        chk("t4_abort_idle_err", 32'(err), 32'd0);
        chk("t4_abort_idle_armed", 32'(armed), 32'd0);

        // 5: blink pattern while armed, then abort
        do_reset();
        send(8'hA2);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("t5_blink%0d", k), 32'(led_verde), 32'(((k / 4) % 2) == 0));
            tick(1);
        end
        send(8'hC3);
        chk("t5_abort_armed", 32'(armed), 32'd0);
        chk("t5_abort_slot", 32'(slot), 32'd0);
        chk("t5_abort_err", 32'(err), 32'd0);
        chk("t5_abort_verde", 32'(led_verde), 32'd1);

        // 6: reset during FIRE, then address wrap on the high-base instance
        do_reset();
        send(8'hA1);
        exp_q.push_back('{addr: 32'h0010_0000, slot: 4'd1});
        send(8'h5A);
        chk("t6_fire_trigger", 32'(trigger), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_reset_vals("t6_rst");
        send(8'hA3);
        chk("t6_main_addr3", boot_address, 32'h0030_0000);
        chk("t6_wrap_addr3", w_boot_address, 32'h0010_0000);
        send(8'hA2);
        chk("t6_wrap_addr2", w_boot_address, 32'h0000_0000);
        tick(2);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
